// File: rtl/cgra_ctrl_pkg.sv
// Shared types and default sizing for the CGRA execution controller,
// PE array and BRAM interface.
package cgra_ctrl_pkg;

  localparam int unsigned IADDR_W_DEF  = 12;
  localparam int unsigned PIPE_LAT_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } exec_state_e;

endpackage

// File: rtl/cgra_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module cgra_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Kernel sequencer for the PE torus: host start/done handshake, instruction
// address stepping, pipeline drain and BRAM-port ownership flag.
module cgra_exec_ctrl
  import cgra_ctrl_pkg::*;
#(
  parameter int unsigned IADDR_W  = IADDR_W_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               Computation_Start,
  output logic               Computation_Done,
  input  logic [IADDR_W-1:0] Cfg_Len,
  input  logic               Stall,
  output logic [IADDR_W-1:0] Inst_Addr,
  output logic               Inst_Rd,
  output logic               PE_Array_Busy,
  output logic [CNT_W-1:0]   Cycle_Count
);

  localparam int unsigned     DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT - 1);

  exec_state_e        state_q, state_d;
  logic [IADDR_W-1:0] len_q, len_d;
  logic [IADDR_W-1:0] addr_q, addr_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               rd_q, rd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_clr_c;
  logic               cnt_en_c;
  logic               last_addr_c;

  // Final instruction of the kernel is currently being presented.
  assign last_addr_c = (addr_q == (len_q - IADDR_W'(1)));

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and next output values; Stall freezes all progress.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    drn_d     = drn_q;
    rd_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Computation_Start) begin
          len_d     = Cfg_Len;
          addr_d    = '0;
          busy_d    = 1'b1;
          cnt_clr_c = 1'b1;
          if (Cfg_Len != '0) begin
            state_d = ST_RUN;
            rd_d    = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            drn_d   = DRN_LOAD;
          end
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (!Stall) begin
          cnt_en_c = 1'b1;
          if (last_addr_c) begin
            state_d = ST_DRAIN;
            drn_d   = DRN_LOAD;
          end else begin
            addr_d = addr_q + IADDR_W'(1);
            rd_d   = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        if (!Stall) begin
          cnt_en_c = 1'b1;
          if (drn_q == '0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            drn_d = drn_q - DRN_W'(1);
          end
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        addr_d = '0;
        if (!Computation_Start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Non-stalled RUN/DRAIN cycles of the current or most recent kernel.
  cgra_sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk   (Clk),
    .rst_n (Resetn),
    .clr   (cnt_clr_c),
    .en    (cnt_en_c),
    .count (Cycle_Count)
  );

  assign Computation_Done = done_q;
  assign Inst_Addr        = addr_q;
  assign Inst_Rd          = rd_q;
  assign PE_Array_Busy    = busy_q;

endmodule
